euler_integrator_bank: RTL and testbench

- Parametrised, multi-channel successor to the single-state Euler integrator used by the Lorenz solver.
- Holds CHANNELS state variables in signed fixed point. Accepts one derivative per channel per step over a valid/ready handshake, scaled by dt = 2^-DT_SHIFT.
- Commits all channels simultaneously, so the derivative datapath always sees a consistent state vector.
- Sits between the derivative (multiplier) datapath and the VGA plotting logic.

---
 rtl/fixed_point_pkg.sv | 39 +++
 rtl/sat_shift_add.sv | 34 +++
 rtl/euler_integrator_bank.sv | 134 +++++++++++++
 tb/tb_euler_integrator_bank.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fixed_point_pkg.sv
// Shared fixed-point definitions for the Euler integrator bank.
// Default word format is 7.20 signed (27 bits, 20 fractional bits).
// Saturating arithmetic is selected by INTEGRATOR_SATURATE_EN.
package fixed_point_pkg;

  localparam int DEF_WIDTH = 27;
  localparam int DEF_FRAC  = 20;

  // 1.0 in the default format.
  localparam logic [DEF_WIDTH-1:0] ONE = DEF_WIDTH'(1) << DEF_FRAC;

  // Step sequencer states.
  typedef enum logic {
    COLLECT = 1'b0,
    COMMIT  = 1'b1
  } step_state_t;

  typedef struct packed {
    logic                 ovf;
    logic [DEF_WIDTH-1:0] value;
  } sat_result_t;

  // Saturating add in the default format; reference helper for the datapath.
  function automatic sat_result_t sat_add(input logic [DEF_WIDTH-1:0] a,
                                          input logic [DEF_WIDTH-1:0] b);
    logic [DEF_WIDTH:0] sum;
    sat_result_t        r;
    sum   = {a[DEF_WIDTH-1], a} + {b[DEF_WIDTH-1], b};
    r.ovf = sum[DEF_WIDTH] ^ sum[DEF_WIDTH-1];
    if (!r.ovf)
      r.value = sum[DEF_WIDTH-1:0];
    else if (sum[DEF_WIDTH])
      r.value = {1'b1, {(DEF_WIDTH-1){1'b0}}};
    else
      r.value = {1'b0, {(DEF_WIDTH-1){1'b1}}};
    return r;
  endfunction

endpackage

// File: rtl/sat_shift_add.sv
// Combinational next-state datapath for one channel: state + (deriv >>> DT_SHIFT).
// With INTEGRATOR_SATURATE_EN defined the sum is formed one bit wider and
// clamped to the signed range, raising o_ovf on a clamp; otherwise it wraps.
module sat_shift_add #(
  parameter int WIDTH    = 27,
  parameter int DT_SHIFT = 8
) (
  input  logic signed [WIDTH-1:0] i_state,
  input  logic signed [WIDTH-1:0] i_deriv,
  output logic        [WIDTH-1:0] o_sum,
  output logic                    o_ovf
);

  // Arithmetic shift rounds toward minus infinity (dt = 2^-DT_SHIFT).
  logic signed [WIDTH-1:0] w_step;
  assign w_step = i_deriv >>> DT_SHIFT;

`ifdef INTEGRATOR_SATURATE_EN
  logic [WIDTH:0] w_wide;
  assign w_wide = {i_state[WIDTH-1], i_state} + {w_step[WIDTH-1], w_step};

  // Clamp when the two top bits of the widened sum disagree.
  always_comb begin
    o_ovf = w_wide[WIDTH] ^ w_wide[WIDTH-1];
    o_sum = w_wide[WIDTH-1:0];
    if (o_ovf)
      o_sum = w_wide[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end
`else
  assign o_sum = i_state + w_step;
  assign o_ovf = 1'b0;
`endif

endmodule

// File: rtl/euler_integrator_bank.sv
// Multi-channel forward-Euler integrator. Derivatives arrive one channel at a
// time (cur_ch order) over a valid/ready handshake and land in shadow
// registers; all channels commit together in a one-cycle COMMIT state.
// Handshake: a derivative is taken on a clk edge where deriv_valid and
// deriv_ready are both high; deriv_ready is high exactly in COLLECT.
// INTEGRATOR_SATURATE_EN selects saturating adds with sticky overflow flags;
// without it adds wrap and overflow stays 0.
module euler_integrator_bank
  import fixed_point_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int FRAC     = DEF_FRAC,
  parameter int CHANNELS = 3,
  parameter int DT_SHIFT = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      init_load,
  input  logic [3:0]                init_ch,
  input  logic [WIDTH-1:0]          init_value,
  input  logic                      deriv_valid,
  output logic                      deriv_ready,
  input  logic [WIDTH-1:0]          deriv_data,
  output logic [3:0]                cur_ch,
  output logic [CHANNELS*WIDTH-1:0] state_out,
  output logic                      step_done,
  output logic [31:0]               step_count,
  output logic [CHANNELS-1:0]       overflow
);

  if (CHANNELS < 1 || CHANNELS > 16 || FRAC >= WIDTH || DT_SHIFT >= WIDTH) begin : g_bad_params
    $error("euler_integrator_bank: illegal parameter combination");
  end

  logic [WIDTH-1:0]    r_state  [CHANNELS];
  logic [WIDTH-1:0]    r_shadow [CHANNELS];
  logic [3:0]          r_cur_ch;
  step_state_t         r_fsm;
  logic                r_step_done;
  logic [31:0]         r_step_count;
  logic [CHANNELS-1:0] r_overflow;

  logic [WIDTH-1:0]    w_cur_state;
  logic [WIDTH-1:0]    w_next;
  logic                w_ovf;

  // Select the committed state of the channel currently being collected.
  always_comb begin
    w_cur_state = '0;
    for (int k = 0; k < CHANNELS; k++)
      if (r_cur_ch == 4'(k)) w_cur_state = r_state[k];
  end

  sat_shift_add #(
    .WIDTH    (WIDTH),
    .DT_SHIFT (DT_SHIFT)
  ) u_sat_shift_add (
    .i_state (w_cur_state),
    .i_deriv (deriv_data),
    .o_sum   (w_next),
    .o_ovf   (w_ovf)
  );

  // Step sequencer: collect shadows per handshake, commit all at once.
  // init_load has priority over everything and aborts a partial step.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < CHANNELS; k++) begin
        r_state[k]  <= '0;
        r_shadow[k] <= '0;
      end
      r_cur_ch     <= '0;
      r_fsm        <= COLLECT;
      r_step_done  <= 1'b0;
      r_step_count <= '0;
      r_overflow   <= '0;
    end else begin
      r_step_done <= 1'b0;
      if (init_load) begin
        // Out-of-range init_ch matches no channel: write dropped, abort kept.
        for (int k = 0; k < CHANNELS; k++) begin
          if (init_ch == 4'(k)) begin
            r_state[k]    <= init_value;
            r_shadow[k]   <= init_value;
            r_overflow[k] <= 1'b0;
          end
        end
        r_cur_ch <= '0;
        r_fsm    <= COLLECT;
      end else begin
        case (r_fsm)
          COLLECT: begin
            if (deriv_valid) begin
              for (int k = 0; k < CHANNELS; k++) begin
                if (r_cur_ch == 4'(k)) begin
                  r_shadow[k] <= w_next;
                  if (w_ovf) r_overflow[k] <= 1'b1;
                end
              end
              if (r_cur_ch == 4'(CHANNELS-1)) begin
                r_cur_ch <= '0;
                r_fsm    <= COMMIT;
              end else begin
                r_cur_ch <= r_cur_ch + 4'd1;
              end
            end
          end
          COMMIT: begin
            for (int k = 0; k < CHANNELS; k++)
              r_state[k] <= r_shadow[k];
            r_step_done  <= 1'b1;
            r_step_count <= r_step_count + 32'd1;
            r_fsm        <= COLLECT;
          end
          default: r_fsm <= COLLECT;
        endcase
      end
    end
  end

  // Flatten committed states, channel k at bits [k*WIDTH +: WIDTH].
  always_comb begin
    state_out = '0;
    for (int k = 0; k < CHANNELS; k++)
      state_out[k*WIDTH +: WIDTH] = r_state[k];
  end

  assign deriv_ready = (r_fsm == COLLECT);
  assign cur_ch      = r_cur_ch;
  assign step_done   = r_step_done;
  assign step_count  = r_step_count;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_euler_integrator_bank.sv
// Directed testbench for euler_integrator_bank (default 3 x 27-bit, DT_SHIFT 8).
// Expected values are hand-computed; saturation expectations follow
// INTEGRATOR_SATURATE_EN.
module tb_euler_integrator_bank;

  localparam int W  = 27;
  localparam int CH = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            init_load;
  logic [3:0]      init_ch;
  logic [W-1:0]    init_value;
  logic            deriv_valid;
  logic            deriv_ready;
  logic [W-1:0]    deriv_data;
  logic [3:0]      cur_ch;
  logic [CH*W-1:0] state_out;
  logic            step_done;
  logic [31:0]     step_count;
  logic [CH-1:0]   overflow;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int hs_cnt = 0;
  int stall_cnt = 0;
  int d0, h0, s0;

  euler_integrator_bank dut (
    .clk         (clk),
    .reset       (reset),
    .init_load   (init_load),
    .init_ch     (init_ch),
    .init_value  (init_value),
    .deriv_valid (deriv_valid),
    .deriv_ready (deriv_ready),
    .deriv_data  (deriv_data),
    .cur_ch      (cur_ch),
    .state_out   (state_out),
    .step_done   (step_done),
    .step_count  (step_count),
    .overflow    (overflow)
  );

  // Clock and event monitors (sampled mid-cycle).
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (step_done === 1'b1) done_cnt++;
    if (deriv_valid && deriv_ready === 1'b1) hs_cnt++;
    if (deriv_valid && deriv_ready === 1'b0) stall_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [3:0] ch, input logic [W-1:0] val);
    init_load  = 1'b1;
    init_ch    = ch;
    init_value = val;
    tick();
    init_load  = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] data);
    deriv_valid = 1'b1;
    deriv_data  = data;
    tick();
    deriv_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; init_load = 1'b0; init_ch = '0; init_value = '0;
    deriv_valid = 1'b0; deriv_data = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // 1. Reset and idle
    check("rst_state", state_out, '0);
    check("rst_count", step_count, 32'd0);
    check("rst_cur_ch", cur_ch, 4'd0);
    check("rst_ready", deriv_ready, 1'b1);
    check("rst_ovf", overflow, '0);
    repeat (5) tick();
    check("idle_no_done", done_cnt, 0);

    // 2. Basic step with mixed signs
    load(4'd0, 27'h0100000);
    load(4'd1, 27'h7E00000);
    load(4'd2, 27'h0000000);
    check("load_state", state_out, {27'h0000000, 27'h7E00000, 27'h0100000});
    d0 = done_cnt;
    send(27'h0100000);
    send(27'h0100000);
    check("mid_cur_ch", cur_ch, 4'd2);
    check("mid_state_hold", state_out, {27'h0000000, 27'h7E00000, 27'h0100000});
    send(27'h7F00000);
    check("commit_ready_low", deriv_ready, 1'b0);
    check("commit_state_hold", state_out, {27'h0000000, 27'h7E00000, 27'h0100000});
    check("commit_no_done", step_done, 1'b0);
    tick();
    check("step1_done", step_done, 1'b1);
    check("step1_state", state_out, {27'h7FFF000, 27'h7E01000, 27'h0101000});
    check("step1_count", step_count, 32'd1);
    check("step1_ready", deriv_ready, 1'b1);
    tick();
    check("step1_done_once", done_cnt - d0, 1);
    check("step1_ovf", overflow, '0);

    // 3. Saturation / wraparound at the range limits
    load(4'd0, 27'h3FFFFFF);
    load(4'd1, 27'h4000000);
    load(4'd2, 27'h0000000);
    send(27'h0100000);
    send(27'h7F00000);
    send(27'h0000000);
    tick();
    check("sat_count", step_count, 32'd2);
`ifdef INTEGRATOR_SATURATE_EN
    check("sat_state", state_out, {27'h0000000, 27'h4000000, 27'h3FFFFFF});
    check("sat_ovf", overflow, 3'b011);
    load(4'd0, 27'h0000000);
    check("sat_ovf_clear", overflow, 3'b010);
`else
    check("wrap_state", state_out, {27'h0000000, 27'h3FFF000, 27'h4000FFF});
    check("wrap_ovf", overflow, 3'b000);
    load(4'd0, 27'h0000000);
    check("wrap_ovf_clear", overflow, 3'b000);
`endif

    // 4. deriv_valid held high across two steps
    load(4'd0, 27'h0000100);
    load(4'd1, 27'h7FFF000);
    load(4'd2, 27'h0010000);
    check("bp_ovf_reload", overflow, '0);
    d0 = done_cnt; h0 = hs_cnt; s0 = stall_cnt;
    deriv_valid = 1'b1;
    deriv_data  = 27'h0200000;
    repeat (8) tick();
    deriv_valid = 1'b0;
    tick();
    check("bp_handshakes", hs_cnt - h0, 6);
    check("bp_stalls", stall_cnt - s0, 2);
    check("bp_done", done_cnt - d0, 2);
    check("bp_count", step_count, 32'd4);
    check("bp_state", state_out, {27'h0014000, 27'h0003000, 27'h0004100});
    check("bp_cur_ch", cur_ch, 4'd0);

    // 5. init_load aborts a partial step
    d0 = done_cnt;
    send(27'h0100000);
    check("abort_pre_cur_ch", cur_ch, 4'd1);
    load(4'd2, 27'h0100000);
    check("abort_cur_ch", cur_ch, 4'd0);
    check("abort_count", step_count, 32'd4);
    check("abort_state", state_out, {27'h0100000, 27'h0003000, 27'h0004100});
    send(27'h0100000);
    // Out-of-range init with a simultaneous handshake: both dropped, abort kept.
    deriv_valid = 1'b1;
    deriv_data  = 27'h0100000;
    load(4'd5, 27'h1234567);
    deriv_valid = 1'b0;
    check("oor_cur_ch", cur_ch, 4'd0);
    check("oor_state", state_out, {27'h0100000, 27'h0003000, 27'h0004100});
    repeat (3) tick();
    check("abort_no_done", done_cnt - d0, 0);
    send(27'h0100000);
    send(27'h0100000);
    send(27'h0100000);
    tick();
    check("post_abort_state", state_out, {27'h0101000, 27'h0004000, 27'h0005100});
    check("post_abort_count", step_count, 32'd5);

    // 6. Reset asserted during COMMIT
    send(27'h0100000);
    send(27'h0100000);
    send(27'h0100000);
    check("pre_rst_commit", deriv_ready, 1'b0);
    reset = 1'b1;
    #1;
    check("async_state", state_out, '0);
    check("async_count", step_count, 32'd0);
    check("async_done", step_done, 1'b0);
    check("async_cur_ch", cur_ch, 4'd0);
    check("async_ovf", overflow, '0);
    check("async_ready", deriv_ready, 1'b1);
    d0 = done_cnt;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) tick();
    check("rst_commit_no_done", done_cnt - d0, 0);
    check("rst_commit_count", step_count, 32'd0);
    check("rst_commit_state", state_out, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
